// File: rtl/tone_sequencer_if.sv
// Bus between the tone sequencer and its surroundings: start request, sine ROM
// address/data and the registered DAC sample with its status flags.
interface tone_sequencer_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              start;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_q;
  logic [7:0]        sample;
  logic              sample_valid;
  logic              busy;
  logic              done;
  logic [1:0]        note_idx;

  modport master (
    input  start,
    input  rom_q,
    output rom_addr,
    output sample,
    output sample_valid,
    output busy,
    output done,
    output note_idx
  );

  modport slave (
    output start,
    output rom_q,
    input  rom_addr,
    input  sample,
    input  sample_valid,
    input  busy,
    input  done,
    input  note_idx
  );
endinterface

// File: rtl/tone_sequencer.sv
// DDS tone sequencer: plays a three-note phrase through a synchronous sine ROM.
// Optional silent gaps between notes are enabled by defining NOTE_GAP_EN.
module tone_sequencer #(
  parameter int unsigned         PHASE_W      = 24,
  parameter int unsigned         ADDR_W       = 10,
  parameter int unsigned         SAMPLE_DIV   = 90,
  parameter int unsigned         NOTE_SAMPLES = 2048,
  parameter logic [PHASE_W-1:0]  TW0          = 24'd4613,
  parameter logic [PHASE_W-1:0]  TW1          = 24'd5811,
  parameter logic [PHASE_W-1:0]  TW2          = 24'd6910,
  parameter int unsigned         GAP_SAMPLES  = 256
) (
  input  logic             CLOCK_25,
  input  logic             reset,
  tone_sequencer_if.master bus
);

  localparam int unsigned CntMax = (NOTE_SAMPLES > GAP_SAMPLES) ? NOTE_SAMPLES : GAP_SAMPLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned DivW   = $clog2(SAMPLE_DIV);

  localparam logic [DivW-1:0] DivLoad  = DivW'(SAMPLE_DIV - 1);
  localparam logic [CntW-1:0] NoteLast = CntW'(NOTE_SAMPLES - 1);
  localparam logic [7:0]      MidScale = 8'd128;

`ifdef NOTE_GAP_EN
  localparam logic [CntW-1:0] GapLast = CntW'(GAP_SAMPLES - 1);
  typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;
`else
  typedef enum logic [1:0] {StIdle, StPlay} state_e;
`endif

  state_e              state_q, state_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DivW-1:0]     div_q, div_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [1:0]          note_q, note_d;
  logic [7:0]          sample_q, sample_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  // Two-stage capture pipeline: ROM latency, then sample register.
  logic [1:0]          pend_q, pend_d;

  logic [PHASE_W-1:0]  tw;
  logic [PHASE_W-1:0]  phase_nx;
  logic                tick;

  always_comb begin
    case (note_q)
      2'd0:    tw = TW0;
      2'd1:    tw = TW1;
      default: tw = TW2;
    endcase
  end

  assign phase_nx = phase_q + tw;
  assign tick     = (div_q == '0);

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    addr_d   = addr_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    note_d   = note_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pend_d   = {pend_q[0], 1'b0};

    if (pend_q[1]) begin
      sample_d = bus.rom_q;
      valid_d  = 1'b1;
    end

    case (state_q)
      StIdle: begin
        phase_d  = '0;
        addr_d   = '0;
        div_d    = DivLoad;
        cnt_d    = '0;
        note_d   = 2'd0;
        sample_d = MidScale;
        valid_d  = 1'b0;
        busy_d   = 1'b0;
        pend_d   = '0;
        if (bus.start) begin
          state_d = StPlay;
          busy_d  = 1'b1;
        end
      end

      StPlay: begin
        div_d = tick ? DivLoad : div_q - 1'b1;
        if (tick) begin
          if (cnt_q == NoteLast) begin
            cnt_d   = '0;
            phase_d = '0;
            addr_d  = '0;
            if (note_q == 2'd2) begin
              // Final tick: its lookup is dropped so nothing follows done.
              state_d  = StIdle;
              note_d   = 2'd0;
              done_d   = 1'b1;
              busy_d   = 1'b0;
              sample_d = MidScale;
              valid_d  = 1'b0;
              pend_d   = '0;
            end else begin
`ifdef NOTE_GAP_EN
              state_d  = StGap;
              sample_d = MidScale;
              valid_d  = 1'b0;
              pend_d   = '0;
`else
              note_d    = note_q + 2'd1;
              pend_d[0] = 1'b1;
`endif
            end
          end else begin
            phase_d   = phase_nx;
            addr_d    = phase_nx[PHASE_W-1 -: ADDR_W];
            cnt_d     = cnt_q + 1'b1;
            pend_d[0] = 1'b1;
          end
        end
      end

`ifdef NOTE_GAP_EN
      StGap: begin
        div_d    = tick ? DivLoad : div_q - 1'b1;
        sample_d = MidScale;
        valid_d  = 1'b0;
        if (tick) begin
          if (cnt_q == GapLast) begin
            cnt_d   = '0;
            note_d  = note_q + 2'd1;
            state_d = StPlay;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`endif

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      phase_q  <= '0;
      addr_q   <= '0;
      div_q    <= DivLoad;
      cnt_q    <= '0;
      note_q   <= 2'd0;
      sample_q <= MidScale;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pend_q   <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      addr_q   <= addr_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      note_q   <= note_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pend_q   <= pend_d;
    end
  end

  assign bus.rom_addr     = addr_q;
  assign bus.sample       = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.note_idx     = note_q;

endmodule
